pipe_ctrl: RTL and testbench

- Central pipeline controller for the 6-stage in-order MIPS core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the shared stall bus and converts MEM-stage exceptions/ERET into a flush plus redirect PC.
- Sequences a post-flush drain so that an in-flight I-cache fetch is discarded before fetch restarts.
- Sits beside the stage registers; its stall/flush outputs drive every stage's pipeline register, including ID.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_stall_encode.sv | 21 ++
 rtl/pipe_ctrl.sv | 97 +++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: StallBus layout, stage indices,
// exception codes and controller state encodings.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned STALL_IDX_W = $clog2(STALL_W);

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int unsigned STAGE_PC  = 0;
    localparam int unsigned STAGE_IF  = 1;
    localparam int unsigned STAGE_ID  = 2;
    localparam int unsigned STAGE_EX  = 3;
    localparam int unsigned STAGE_MEM = 4;
    localparam int unsigned STAGE_WB  = 5;

    localparam logic [31:0] EXCODE_ERET = 32'h0000_000E;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Stop every stage from PC up to and including 'stage'; later stages run.
    function automatic stall_bus_t stop_upto(input int unsigned stage);
        stall_bus_t m;
        m = {STALL_W{NOSTOP}};
        for (int unsigned k = 0; k < STALL_W; k++) begin
            if (k <= stage) m[STALL_IDX_W'(k)] = STOP;
        end
        return m;
    endfunction

    localparam stall_bus_t STALL_DRAIN = stop_upto(STAGE_IF);

endpackage

// File: rtl/pipe_ctrl_stall_encode.sv
// Priority encoder from per-stage stall requests to the StallBus mask;
// the latest stage requesting wins.
module stall_encode
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output stall_bus_t stall
);

    always_comb begin
        if (stallreq_mem)     stall = stop_upto(STAGE_MEM);
        else if (stallreq_ex) stall = stop_upto(STAGE_EX);
        else if (stallreq_id) stall = stop_upto(STAGE_ID);
        else if (stallreq_if) stall = stop_upto(STAGE_IF);
        else                  stall = '0;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests, turns MEM-stage
// exceptions/ERET into flush + redirect, and drains I-cache fetches after a flush.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned DRAIN_MIN  = 1,
    parameter int unsigned WDOG_MAX   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc,
    input  logic        ic_busy,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_err,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    logic [0:0]  state_q;
    logic [15:0] drain_cnt_q;
    logic [31:0] new_pc_q;
    logic [31:0] redirect;
    logic [31:0] cnt_next1;
    logic        drain_done;
    logic        wdog_hit;
    stall_bus_t  run_stall;

    stall_encode u_stall_encode (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall        (run_stall)
    );

    assign redirect   = (excepttype_i == EXCODE_ERET) ? cp0_epc : EXC_VECTOR;
    assign cnt_next1  = 32'(drain_cnt_q) + 32'd1;
    assign drain_done = (cnt_next1 >= DRAIN_MIN) && !ic_busy;
    assign wdog_hit   = (cnt_next1 >= WDOG_MAX) && ic_busy;

    // Mealy in RUN, Moore in DRAIN; forced quiet while reset is asserted.
    always_comb begin
        stall = '0;
        flush = 1'b0;
        if (!rst) begin
            if (state_q == ST_RUN) begin
                if (excepttype_i != '0) flush = 1'b1;
                else                    stall = run_stall;
            end else begin
                stall = STALL_DRAIN;
            end
        end
    end

    assign new_pc = flush ? redirect : new_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            new_pc_q    <= '0;
            wdog_err    <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            wdog_err <= 1'b0;
            if ((stall != '0) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;

            if (state_q == ST_RUN) begin
                if (flush) begin
                    state_q     <= ST_DRAIN;
                    drain_cnt_q <= '0;
                    new_pc_q    <= redirect;
                    flush_cnt   <= flush_cnt + 16'd1;
                end
            end else begin
                if (drain_done) begin
                    state_q <= ST_RUN;
                end else if (wdog_hit) begin
                    state_q  <= ST_RUN;
                    wdog_err <= 1'b1;
                end else begin
                    drain_cnt_q <= drain_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of stall-priority vectors plus
// hand-written exception, ERET, drain, watchdog and reset sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc;
    logic        ic_busy;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdog_err;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;
    int sc_model = 0;
    int fc_model = 0;
    int n;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR (32'hBFC0_0380),
        .DRAIN_MIN  (3),
        .WDOG_MAX   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc      (cp0_epc),
        .ic_busy      (ic_busy),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .wdog_err     (wdog_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    typedef struct {
        logic [3:0] req;        // {mem, ex, id, if}
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
    endtask

    // Count consecutive DRAIN cycles; ic_busy held high for the first busy_cycles of them.
    task automatic drain_run(input int busy_cycles, output int cnt);
        bit ended;
        cnt = 0;
        ended = 0;
        for (int i = 0; i < 40 && !ended; i++) begin
            ic_busy = (cnt < busy_cycles);
            @(negedge clk);
            if (stall == 6'b000011 && !flush) begin
                cnt++;
                sc_model++;
                next_cycle();
            end else begin
                ended = 1;
            end
        end
        if (!ended) chk("drain_bound", 32'(cnt), 32'd0);
        ic_busy = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0000, 6'b000000};
        vecs[1] = '{4'b0001, 6'b000011};
        vecs[2] = '{4'b0010, 6'b000111};
        vecs[3] = '{4'b1010, 6'b011111};
        vecs[4] = '{4'b0100, 6'b001111};
        vecs[5] = '{4'b1000, 6'b011111};
        vecs[6] = '{4'b0011, 6'b000111};
        vecs[7] = '{4'b0111, 6'b001111};
        vecs[8] = '{4'b0101, 6'b001111};
        vecs[9] = '{4'b1111, 6'b011111};

        rst = 1'b1;
        set_req(4'b1111);
        excepttype_i = '0;
        cp0_epc = '0;
        ic_busy = 1'b0;
        @(negedge clk);
        chk("rst_stall_gated", 32'(stall), 32'd0);
        chk("rst_flush_gated", 32'(flush), 32'd0);
        next_cycle();
        set_req(4'b0000);
        @(negedge clk);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_wdog", 32'(wdog_err), 32'd0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].req);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'd0);
            if (vecs[i].exp_stall != 6'b0) sc_model++;
            next_cycle();
            chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, 32'(sc_model));
        end
        set_req(4'b0000);

        // Exception beats a D-cache stall; drain with idle I-cache lasts DRAIN_MIN.
        stallreq_mem = 1'b1;
        excepttype_i = 32'h8;
        cp0_epc = 32'h1234_5678;
        @(negedge clk);
        chk("exc_flush", 32'(flush), 32'd1);
        chk("exc_stall", 32'(stall), 32'd0);
        chk("exc_new_pc", new_pc, 32'hBFC0_0380);
        fc_model++;
        next_cycle();
        stallreq_mem = 1'b0;
        chk("exc_flush_cnt", 32'(flush_cnt), 32'(fc_model));
        chk("exc_no_stall_count", stall_cnt, 32'(sc_model));
        @(negedge clk);
        chk("drain_stall", 32'(stall), 32'h03);
        chk("drain_flush_ignored", 32'(flush), 32'd0);
        chk("drain_new_pc_held", new_pc, 32'hBFC0_0380);
        sc_model++;
        next_cycle();
        excepttype_i = '0;
        drain_run(0, n);
        chk("drain_min_len", 32'(n + 1), 32'd3);
        chk("drain_exit_stall", 32'(stall), 32'd0);
        chk("drain_exit_wdog", 32'(wdog_err), 32'd0);
        chk("drain_stall_cnt", stall_cnt, 32'(sc_model));
        chk("drain_flush_cnt", 32'(flush_cnt), 32'(fc_model));
        next_cycle();

        // ERET redirects to EPC; I-cache busy through flush + 4 drain cycles.
        cp0_epc = 32'h8000_1234;
        excepttype_i = 32'hE;
        ic_busy = 1'b1;
        @(negedge clk);
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_new_pc", new_pc, 32'h8000_1234);
        fc_model++;
        next_cycle();
        excepttype_i = '0;
        drain_run(4, n);
        chk("drain_busy_len", 32'(n), 32'd5);
        chk("eret_new_pc_held", new_pc, 32'h8000_1234);
        chk("eret_flush_cnt", 32'(flush_cnt), 32'(fc_model));
        next_cycle();

        // Watchdog: I-cache stuck busy.
        excepttype_i = 32'h4;
        ic_busy = 1'b1;
        @(negedge clk);
        chk("wd_flush", 32'(flush), 32'd1);
        fc_model++;
        next_cycle();
        excepttype_i = '0;
        drain_run(1000, n);
        chk("wd_len", 32'(n), 32'd8);
        chk("wd_pulse", 32'(wdog_err), 32'd1);
        chk("wd_stall_cnt", stall_cnt, 32'(sc_model));
        next_cycle();
        @(negedge clk);
        chk("wd_pulse_end", 32'(wdog_err), 32'd0);
        next_cycle();

        // Reset during the 2nd DRAIN cycle.
        excepttype_i = 32'h8;
        @(negedge clk);
        chk("rd_flush", 32'(flush), 32'd1);
        next_cycle();
        excepttype_i = '0;
        ic_busy = 1'b1;
        @(negedge clk);
        chk("rd_drain1", 32'(stall), 32'h03);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        ic_busy = 1'b0;
        @(negedge clk);
        chk("rd_stall", 32'(stall), 32'd0);
        chk("rd_flush0", 32'(flush), 32'd0);
        chk("rd_stall_cnt", stall_cnt, 32'd0);
        chk("rd_flush_cnt", 32'(flush_cnt), 32'd0);
        next_cycle();
        stallreq_id = 1'b1;
        @(negedge clk);
        chk("rd_run_state", 32'(stall), 32'h07);
        next_cycle();
        stallreq_id = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
